// File: rtl/instr_realign_pkg.sv
// rtl/instr_realign_pkg.sv - shared frontend constants, FSM state type and RVC helper
package instr_realign_pkg;

    localparam int HW_DW    = 16;
    localparam int FETCH_HW = 4;
    localparam logic [63:0] RESET_PC_DEFAULT = 64'h8000_0000;

    typedef enum logic {
        ST_ALIGN  = 1'b0,
        ST_STREAM = 1'b1
    } realign_state_e;

    // A halfword starts a compressed instruction unless its low two bits are 2'b11.
    function automatic logic is_rvc(input logic [HW_DW-1:0] hw);
        return hw[1:0] != 2'b11;
    endfunction

endpackage

// File: rtl/instr_realign_hw_ringbuf.sv
// rtl/instr_realign_hw_ringbuf.sv - halfword ring, 0..4 push and 1/2 pop per cycle
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   clr               discard contents and rewind pointers (takes priority over push/pop)
//   push_en           write push_n halfwords of push_data starting at halfword push_first
//   push_first/push_n first source halfword index and number of halfwords to write
//   push_data         four halfwords, [15:0] lowest address
//   pop_en/pop_two    retire one (or two when pop_two) halfwords from the head
//   count             current occupancy in halfwords
//   h0/h1             head halfword and the one after it (wrapping)
module hw_ringbuf
    import instr_realign_pkg::*;
#(
    parameter int BUF_HW = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clr,
    input  logic                       push_en,
    input  logic [1:0]                 push_first,
    input  logic [2:0]                 push_n,
    input  logic [FETCH_HW*HW_DW-1:0]  push_data,
    input  logic                       pop_en,
    input  logic                       pop_two,
    output logic [$clog2(BUF_HW):0]    count,
    output logic [HW_DW-1:0]           h0,
    output logic [HW_DW-1:0]           h1
);

    localparam int AW = $clog2(BUF_HW);

    logic [HW_DW-1:0] buf_q [BUF_HW];
    logic [HW_DW-1:0] buf_d [BUF_HW];
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic [2:0]       push_amt;
    logic [1:0]       pop_amt;
    logic [1:0]       src_idx;

    always_comb begin
        buf_d    = buf_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        push_amt = push_en ? push_n : 3'd0;
        pop_amt  = pop_en ? (pop_two ? 2'd2 : 2'd1) : 2'd0;
        src_idx  = 2'd0;
        if (clr) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            // Source halfword first+i lands at ring slot wr_ptr+i; pointer arithmetic wraps naturally.
            for (int i = 0; i < FETCH_HW; i++) begin
                src_idx = push_first + 2'(i);
                if (3'(i) < push_amt) begin
                    buf_d[wr_ptr_q + AW'(i)] = push_data[{src_idx, 4'b0000} +: HW_DW];
                end
            end
            wr_ptr_d = wr_ptr_q + AW'(push_amt);
            rd_ptr_d = rd_ptr_q + AW'(pop_amt);
            count_d  = count_q + (AW+1)'(push_amt) - (AW+1)'(pop_amt);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: count gates every read of it.
    always_ff @(posedge clk) begin
        buf_q <= buf_d;
    end

    assign count = count_q;
    assign h0    = buf_q[rd_ptr_q];
    assign h1    = buf_q[rd_ptr_q + AW'(1)];

endmodule

// File: rtl/instr_realign.sv
// rtl/instr_realign.sv - realigns 64-bit fetch blocks into one 16/32-bit instruction per handshake
//
// Ports:
//   CLK, RST                        clock, synchronous active-high reset
//   flush, flush_pc                 redirect: drop buffered halfwords, restart at flush_pc
//   fetch_valid/fetch_ready/fetch_data   8-byte aligned fetch block input
//   instr_valid/instr_ready         aligned instruction handshake
//   instr, instr_pc, is_rvc         presented instruction, its PC, compressed flag
module instr_realign
    import instr_realign_pkg::*;
#(
    parameter int          BUF_HW   = 8,
    parameter logic [63:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        flush,
    input  logic [63:0] flush_pc,
    input  logic        fetch_valid,
    output logic        fetch_ready,
    input  logic [63:0] fetch_data,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [63:0] instr_pc,
    output logic        is_rvc
);

    localparam int AW = $clog2(BUF_HW);

    realign_state_e state_q, state_d;
    logic [63:0]    cur_pc_q, cur_pc_d;
    logic [1:0]     skip_q, skip_d;

    logic [AW:0]        ring_count;
    logic [HW_DW-1:0]   h0, h1;
    logic               head_rvc;
    logic               push, pop;
    logic [1:0]         push_first;
    logic [2:0]         push_n;

    always_comb begin
        head_rvc    = instr_realign_pkg::is_rvc(h0);
        // Room for a full block is decided from registered occupancy only, so the
        // fetch side never waits on the consumer's ready.
        fetch_ready = ~RST & ~flush & (ring_count <= (AW+1)'(BUF_HW - FETCH_HW));
        instr_valid = ~RST & ~flush &
                      (((ring_count != '0) & head_rvc) | (ring_count >= (AW+1)'(2)));
        instr       = head_rvc ? {16'b0, h0} : {h1, h0};
        instr_pc    = cur_pc_q;
        is_rvc      = head_rvc;
        push        = fetch_valid & fetch_ready;
        pop         = instr_valid & instr_ready;
        // After a redirect the first block holds halfwords below the target PC; drop them.
        push_first  = (state_q == ST_ALIGN) ? skip_q : 2'd0;
        push_n      = 3'd4 - {1'b0, push_first};
    end

    always_comb begin
        state_d  = state_q;
        cur_pc_d = cur_pc_q;
        skip_d   = skip_q;
        if (flush) begin
            state_d  = ST_ALIGN;
            cur_pc_d = flush_pc;
            skip_d   = flush_pc[2:1];
        end else begin
            if (push) begin
                state_d = ST_STREAM;
            end
            if (pop) begin
                cur_pc_d = cur_pc_q + (head_rvc ? 64'd2 : 64'd4);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= ST_ALIGN;
            cur_pc_q <= RESET_PC;
            skip_q   <= RESET_PC[2:1];
        end else begin
            state_q  <= state_d;
            cur_pc_q <= cur_pc_d;
            skip_q   <= skip_d;
        end
    end

    hw_ringbuf #(
        .BUF_HW (BUF_HW)
    ) u_ring (
        .clk        (CLK),
        .rst        (RST),
        .clr        (flush),
        .push_en    (push),
        .push_first (push_first),
        .push_n     (push_n),
        .push_data  (fetch_data),
        .pop_en     (pop),
        .pop_two    (~head_rvc),
        .count      (ring_count),
        .h0         (h0),
        .h1         (h1)
    );

endmodule
